// File: rtl/miner_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : miner_job_sched
// Purpose  : Mining job scheduler. Takes one 80-byte (20-word) block header
//            from the host header FIFO, broadcasts it to NUM_LANES nonce
//            lanes, splits the nonce range evenly and sequences
//            start / load / run / stop, then signals completion.
// Options  : SCHED_STATS_EN - adds job_cnt[15:0] and run_cycles[31:0] ports.
// Revision : 1.0 - initial release
// ============================================================================
module miner_job_sched #(
  parameter int NUM_LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_go,
  input  logic                 abort,
  input  logic                 found,
  input  logic [31:0]          nonce_range,
  input  logic [31:0]          hdr_fifo_dout,
  input  logic                 hdr_fifo_empty,
  output logic                 hdr_fifo_rd,
  output logic [31:0]          lane_hdr_word,
  output logic                 lane_hdr_we,
  output logic [31:0]          lane_nonce_size,
  output logic [NUM_LANES-1:0] lane_start,
  output logic                 lane_stop,
  input  logic [NUM_LANES-1:0] lane_stop_ack,
  output logic                 busy,
  output logic                 job_done,
  output logic                 job_aborted
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]          job_cnt,
  output logic [31:0]          run_cycles
`endif
);

  // Lane count is a power of two, so the per-lane span is a plain shift.
  localparam int         c_SHIFT     = $clog2(NUM_LANES);
  localparam logic [4:0] c_LAST_WORD = 5'd19;
  localparam logic [4:0] c_HDR_WORDS = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_START      = 3'd2,
    S_LOAD       = 3'd3,
    S_RUN        = 3'd4,
    S_STOPPING   = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t                 r_state;
  logic [4:0]             r_word_cnt;
  logic                   r_kill;
  logic [31:0]            r_nonce_size;
  logic [NUM_LANES-1:0]   r_lane_start;
  logic                   r_lane_stop;
  logic                   r_busy;
  logic                   r_job_done;
  logic                   r_job_aborted;

  logic                   w_all_ack;
  logic                   w_kill_in;
  logic                   w_kill;
  logic                   w_load;
  logic                   w_rd;
  logic                   w_kill_window;

  assign w_all_ack     = &lane_stop_ack;
  assign w_kill_in     = abort | found;
  // A kill seen this cycle acts at once, without waiting for the latch.
  assign w_kill        = r_kill | w_kill_in;
  assign w_load        = (r_state == S_LOAD);
  assign w_rd          = w_load && !hdr_fifo_empty && (r_word_cnt < c_HDR_WORDS);
  assign w_kill_window = (r_state == S_WAIT_READY) || (r_state == S_START) ||
                         (r_state == S_LOAD)       || (r_state == S_RUN);

  // Header path is combinational so a FWFT word is written the cycle it is read.
  assign hdr_fifo_rd     = w_rd;
  assign lane_hdr_we     = w_rd;
  assign lane_hdr_word   = w_load ? hdr_fifo_dout : 32'h0;

  assign lane_nonce_size = r_nonce_size;
  assign lane_start      = r_lane_start;
  assign lane_stop       = r_lane_stop;
  assign busy            = r_busy;
  assign job_done        = r_job_done;
  assign job_aborted     = r_job_aborted;

  // Kill latch: remembers abort/found until the job returns to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_kill <= 1'b0;
    end else if (w_kill_in && w_kill_window) begin
      r_kill <= 1'b1;
    end
  end

  // Job sequencing FSM with registered lane/host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_word_cnt    <= 5'd0;
      r_nonce_size  <= 32'h0;
      r_lane_start  <= '0;
      r_lane_stop   <= 1'b0;
      r_busy        <= 1'b0;
      r_job_done    <= 1'b0;
      r_job_aborted <= 1'b0;
    end else begin
      r_lane_start <= '0;
      r_job_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_go) begin
            r_nonce_size  <= nonce_range >> c_SHIFT;
            r_job_aborted <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          // Nothing has been handed to the lanes yet, so a kill ends the job here.
          if (w_kill) begin
            r_job_done    <= 1'b1;
            r_job_aborted <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else if (w_all_ack) begin
            r_lane_start <= '1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_word_cnt <= 5'd0;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          // Lanes only honour stop after a full header, so kill waits for word 20.
          if (w_rd) begin
            r_word_cnt <= r_word_cnt + 5'd1;
            if (r_word_cnt == c_LAST_WORD) begin
              if (w_kill) begin
                r_lane_stop <= 1'b1;
                r_state     <= S_STOPPING;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          // Range exhaustion wins over a kill arriving in the same cycle.
          if (w_all_ack) begin
            r_job_aborted <= 1'b0;
            r_job_done    <= 1'b1;
            r_state       <= S_DONE;
          end else if (w_kill) begin
            r_lane_stop <= 1'b1;
            r_state     <= S_STOPPING;
          end
        end
        S_STOPPING: begin
          if (w_all_ack) begin
            r_lane_stop   <= 1'b0;
            r_job_aborted <= 1'b1;
            r_job_done    <= 1'b1;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_lane_stop <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] r_job_cnt;
  logic [31:0] r_run_cycles;
  logic        w_counting;

  assign w_counting = (r_state == S_LOAD) || (r_state == S_RUN) ||
                      (r_state == S_STOPPING);

  // Job counter wraps; run-cycle counter restarts per job and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job_cnt    <= 16'h0;
      r_run_cycles <= 32'h0;
    end else begin
      if (r_job_done) begin
        r_job_cnt <= r_job_cnt + 16'h1;
      end
      if (r_state == S_START) begin
        r_run_cycles <= 32'h0;
      end else if (w_counting && (r_run_cycles != 32'hFFFF_FFFF)) begin
        r_run_cycles <= r_run_cycles + 32'h1;
      end
    end
  end

  assign job_cnt    = r_job_cnt;
  assign run_cycles = r_run_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_miner_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_miner_job_sched
// Purpose  : Directed self-checking bench for miner_job_sched (NUM_LANES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_miner_job_sched;

  localparam int NUM_LANES = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 job_go;
  logic                 abort;
  logic                 found;
  logic [31:0]          nonce_range;
  logic [31:0]          hdr_fifo_dout;
  logic                 hdr_fifo_empty;
  logic                 hdr_fifo_rd;
  logic [31:0]          lane_hdr_word;
  logic                 lane_hdr_we;
  logic [31:0]          lane_nonce_size;
  logic [NUM_LANES-1:0] lane_start;
  logic                 lane_stop;
  logic [NUM_LANES-1:0] lane_stop_ack;
  logic                 busy;
  logic                 job_done;
  logic                 job_aborted;
`ifdef SCHED_STATS_EN
  logic [15:0]          job_cnt;
  logic [31:0]          run_cycles;
`endif

  always #5 clk = ~clk;

  miner_job_sched #(.NUM_LANES(NUM_LANES)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .job_go         (job_go),
    .abort          (abort),
    .found          (found),
    .nonce_range    (nonce_range),
    .hdr_fifo_dout  (hdr_fifo_dout),
    .hdr_fifo_empty (hdr_fifo_empty),
    .hdr_fifo_rd    (hdr_fifo_rd),
    .lane_hdr_word  (lane_hdr_word),
    .lane_hdr_we    (lane_hdr_we),
    .lane_nonce_size(lane_nonce_size),
    .lane_start     (lane_start),
    .lane_stop      (lane_stop),
    .lane_stop_ack  (lane_stop_ack),
    .busy           (busy),
    .job_done       (job_done),
    .job_aborted    (job_aborted)
`ifdef SCHED_STATS_EN
    ,
    .job_cnt        (job_cnt),
    .run_cycles     (run_cycles)
`endif
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_rd, n_we, n_start, n_stop, n_done;
  int          first_we, last_we;
  int          cyc = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_drive();
    hdr_fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) hdr_fifo_dout = fifo_q[0];
    else                    hdr_fifo_dout = 32'h0;
  endtask

  // One clock: observe at the falling edge, apply FIFO pops and lane reactions after the rising edge.
  task automatic tick();
    logic                 pop;
    logic [NUM_LANES-1:0] st;
    @(negedge clk);
    pop = hdr_fifo_rd;
    st  = lane_start;
    if (hdr_fifo_rd) n_rd++;
    if (lane_hdr_we) begin
      n_we++;
      got_q.push_back(lane_hdr_word);
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
    if (lane_start != '0) n_start++;
    if (lane_stop) n_stop++;
    if (job_done) n_done++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    lane_stop_ack = lane_stop_ack & ~st;
    fifo_drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_job();
    n_rd = 0; n_we = 0; n_start = 0; n_stop = 0; n_done = 0;
    first_we = -1; last_we = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic preload(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 32'(i));
      exp_q.push_back(base + 32'(i));
    end
    fifo_drive();
  endtask

  task automatic start_job(input logic [31:0] range);
    job_go      = 1'b1;
    nonce_range = range;
    tick();
    job_go      = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int target);
    int k = 0;
    while (got_q.size() < target && k < 200) begin
      tick();
      k++;
    end
    check_val(tag, 32'(got_q.size()), 32'(target));
  endtask

  task automatic cmp_words(input string tag);
    int nmis = 0;
    if (got_q.size() != exp_q.size()) nmis++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nmis++;
    check_val(tag, 32'(nmis), 32'd0);
  endtask

  task automatic check_reset_outputs(input string p);
    check_val({p, "_rd"},    32'(hdr_fifo_rd),   32'd0);
    check_val({p, "_we"},    32'(lane_hdr_we),   32'd0);
    check_val({p, "_word"},  lane_hdr_word,      32'd0);
    check_val({p, "_start"}, 32'(lane_start),    32'd0);
    check_val({p, "_stop"},  32'(lane_stop),     32'd0);
    check_val({p, "_nsize"}, lane_nonce_size,    32'd0);
    check_val({p, "_busy"},  32'(busy),          32'd0);
    check_val({p, "_done"},  32'(job_done),      32'd0);
    check_val({p, "_abrt"},  32'(job_aborted),   32'd0);
  endtask

  // Job launched with acks high: job_go, WAIT_READY, START; returns in the first LOAD cycle.
  task automatic launch(input logic [31:0] range);
    start_job(range);
    ticks(2);
  endtask

  task automatic finish_natural(input string p);
    lane_stop_ack = '1;
    tick();
    check_val({p, "_done"}, 32'(job_done),    32'd1);
    check_val({p, "_abrt"}, 32'(job_aborted), 32'd0);
    tick();
    check_val({p, "_idle"}, 32'(busy),        32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; job_go = 1'b0; abort = 1'b0; found = 1'b0;
    nonce_range = 32'h0; lane_stop_ack = '1;
    clr_job();
    fifo_drive();
    ticks(2);
    check_reset_outputs("rst0");
`ifdef SCHED_STATS_EN
    check_val("rst0_jobcnt", 32'(job_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // ---- Normal job: 0x100 range across 4 lanes, 20 back-to-back words
    clr_job();
    preload(20, 32'hA000_0000);
    start_job(32'h100);
    check_val("t1_nsize", lane_nonce_size, 32'h40);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_wait_start", 32'(lane_start), 32'h0);
    tick();
    check_val("t1_start", 32'(lane_start), 32'hF);
    check_val("t1_start_rd", 32'(hdr_fifo_rd), 32'd0);
    tick();
    check_val("t1_load_start", 32'(lane_start), 32'h0);
    check_val("t1_first_rd", 32'(hdr_fifo_rd), 32'd1);
    check_val("t1_first_word", lane_hdr_word, 32'hA000_0000);
    wait_words("t1_words", 20);
    check_val("t1_we_span", 32'(last_we - first_we), 32'd19);
    check_val("t1_start_cycles", 32'(n_start), 32'd1);
    check_val("t1_run_rd", 32'(hdr_fifo_rd), 32'd0);
    ticks(3);
    check_val("t1_run_done", 32'(n_done), 32'd0);
    check_val("t1_run_busy", 32'(busy), 32'd1);
    finish_natural("t1");
    cmp_words("t1_data");
`ifdef SCHED_STATS_EN
    check_val("t1_jobcnt", 32'(job_cnt), 32'd1);
`endif

    // ---- FIFO runs dry after word 7, refilled 10 cycles later
    clr_job();
    preload(7, 32'hB000_0000);
    launch(32'h100);
    wait_words("t2_first7", 7);
    n_rd = 0; n_we = 0;
    ticks(10);
    check_val("t2_gap_rd", 32'(n_rd), 32'd0);
    check_val("t2_gap_we", 32'(n_we), 32'd0);
    preload(13, 32'hB000_0007);
    fifo_q.push_back(32'hDEAD_BEEF);
    fifo_drive();
    wait_words("t2_words", 20);
    ticks(2);
    check_val("t2_no_extra", 32'(got_q.size()), 32'd20);
    check_val("t2_left", 32'(fifo_q.size()), 32'd1);
    check_val("t2_no_stop", 32'(n_stop), 32'd0);
    finish_natural("t2");
    cmp_words("t2_data");
    fifo_q.delete();
    fifo_drive();

    // ---- Abort at word 12: header still completes, then stop handshake
    clr_job();
    preload(20, 32'hC000_0000);
    launch(32'h100);
    wait_words("t3_first12", 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_words("t3_words", 20);
    check_val("t3_stop", 32'(lane_stop), 32'd1);
    ticks(3);
    check_val("t3_stop_hold", 32'(lane_stop), 32'd1);
    check_val("t3_no_done", 32'(n_done), 32'd0);
    lane_stop_ack = '1;
    tick();
    check_val("t3_done", 32'(job_done), 32'd1);
    check_val("t3_abrt", 32'(job_aborted), 32'd1);
    check_val("t3_stop_rel", 32'(lane_stop), 32'd0);
    tick();
    check_val("t3_idle", 32'(busy), 32'd0);
    check_val("t3_abrt_held", 32'(job_aborted), 32'd1);
    check_val("t3_fifo_left", 32'(fifo_q.size()), 32'd0);
    cmp_words("t3_data");

    // ---- found in RUN while lane 2 already idle
    clr_job();
    preload(20, 32'hD000_0000);
    launch(32'h100);
    check_val("t4_abrt_clr", 32'(job_aborted), 32'd0);
    wait_words("t4_words", 20);
    lane_stop_ack = 4'b0100;
    ticks(2);
    check_val("t4_run_nostop", 32'(lane_stop), 32'd0);
    found = 1'b1;
    tick();
    found = 1'b0;
    check_val("t4_stop", 32'(lane_stop), 32'd1);
    n_done = 0;
    ticks(3);
    check_val("t4_stop_hold", 32'(lane_stop), 32'd1);
    lane_stop_ack = '1;
    tick();
    check_val("t4_abrt", 32'(job_aborted), 32'd1);
    ticks(2);
    check_val("t4_one_done", 32'(n_done), 32'd1);

    // ---- job_go while busy, and lanes not ready (ack=1011)
    clr_job();
    preload(20, 32'hE000_0000);
    lane_stop_ack = 4'b1011;
    start_job(32'h100);
    start_job(32'h800);
    check_val("t5_go_ignored", lane_nonce_size, 32'h40);
    ticks(5);
    check_val("t5_withheld", 32'(n_start), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd1);
    lane_stop_ack = '1;
    tick();
    check_val("t5_start", 32'(lane_start), 32'hF);
    tick();
    wait_words("t5_words", 20);
    finish_natural("t5");
    check_val("t5_start_cycles", 32'(n_start), 32'd1);

    // ---- Kill while waiting for lanes: immediate aborted completion, no reads
    clr_job();
    fifo_q.push_back(32'h1234_5678);
    fifo_drive();
    lane_stop_ack = 4'b1011;
    start_job(32'h100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t6_done", 32'(job_done), 32'd1);
    check_val("t6_abrt", 32'(job_aborted), 32'd1);
    check_val("t6_idle", 32'(busy), 32'd0);
    tick();
    check_val("t6_pulse", 32'(job_done), 32'd0);
    check_val("t6_no_rd", 32'(n_rd), 32'd0);
    check_val("t6_fifo", 32'(fifo_q.size()), 32'd1);
    fifo_q.delete();
    fifo_drive();
    lane_stop_ack = '1;

    // ---- Kill in the same cycle all acks rise in RUN counts as natural
    clr_job();
    preload(20, 32'h5000_0000);
    launch(32'h1000);
    check_val("t7_nsize", lane_nonce_size, 32'h400);
    wait_words("t7_words", 20);
    tick();
    abort = 1'b1;
    lane_stop_ack = '1;
    tick();
    abort = 1'b0;
    check_val("t7_done", 32'(job_done), 32'd1);
    check_val("t7_abrt", 32'(job_aborted), 32'd0);
    tick();

    // ---- Reset in RUN, then a fresh job
    clr_job();
    preload(20, 32'h6000_0000);
    launch(32'h100);
    wait_words("t8_words", 20);
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("t8_rst");
`ifdef SCHED_STATS_EN
    check_val("t8_jobcnt", 32'(job_cnt), 32'd0);
`endif
    rst = 1'b0;
    lane_stop_ack = '1;
    tick();
    clr_job();
    preload(20, 32'h7000_0000);
    launch(32'h100);
    wait_words("t8_words2", 20);
    finish_natural("t8");
    cmp_words("t8_data");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/miner_job_sched.md
# miner_job_sched

Job scheduler for the mining datapath. It takes one 80-byte block header job from the host header FIFO and broadcasts it to NUM_LANES nonce-generator lanes. Lane i is instantiated with NONCE_COEF = i+1. The scheduler hands every lane the same per-lane nonce range, sequences start, header load, run and stop, and reports job completion to the host register block.

## Interface
Parameters:
- NUM_LANES, 4, number of nonce-generator lanes; power of two, 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- job_go  in  1  host pulse: start a new job.
- abort  in  1  host pulse: terminate current job.
- found  in  1  hash checker pulse: golden nonce found, terminate job.
- nonce_range  in  32  total nonce span of the job, sampled on accepted job_go.
- hdr_fifo_dout  in  32  header FIFO data, first-word-fall-through.
- hdr_fifo_empty  in  1  header FIFO empty.
- hdr_fifo_rd  out  1  header FIFO read enable.
- lane_hdr_word  out  32  header word broadcast to all lanes.
- lane_hdr_we  out  1  header word write enable to all lanes.
- lane_nonce_size  out  32  per-lane nonce span.
- lane_start  out  NUM_LANES  per-lane start pulse.
- lane_stop  out  1  stop request to all lanes.
- lane_stop_ack  in  NUM_LANES  per-lane idle/ready flag; high while the lane is in its init state.
- busy  out  1  job in progress.
- job_done  out  1  one-cycle completion pulse.
- job_aborted  out  1  qualifies job_done: job ended via abort/found; held until next job_go.

## Operation
State machine with states IDLE, WAIT_READY, START, LOAD, RUN, STOPPING, DONE.
- IDLE: busy=0.
  - job_go -> latch lane_nonce_size = nonce_range >> log2(NUM_LANES) (remainder discarded), clear job_aborted, go to WAIT_READY.
  - job_go while busy is ignored.
- WAIT_READY: wait until lane_stop_ack is all ones, then go to START.
- START: lane_start = all ones for exactly one cycle, then go to LOAD with word_cnt=0.
- LOAD:
  - hdr_fifo_rd = !hdr_fifo_empty && word_cnt<20.
  - lane_hdr_word = hdr_fifo_dout and lane_hdr_we = hdr_fifo_rd, both combinational.
  - word_cnt increments on each read.
  - When word_cnt==20: go to STOPPING if the kill latch is set, else go to RUN.
  - An empty FIFO stalls LOAD indefinitely.
- RUN:
  - All lane_stop_ack high -> job_aborted=0, go to DONE (natural range exhaustion).
  - Kill latch set -> go to STOPPING.
- STOPPING: lane_stop=1, held until lane_stop_ack is all ones, then job_aborted=1, go to DONE.
- DONE: job_done=1 for one cycle, return to IDLE.
- Kill latch:
  - Set by abort or found in any state from WAIT_READY to RUN.
  - Cleared on entry to IDLE.
  - In WAIT_READY, a kill returns to IDLE with a job_done pulse and job_aborted=1; no FIFO words are consumed.
- Kill during LOAD never truncates the header: lanes accept stop only after loading, so all 20 words are consumed first.
- A lane finishing early while others still run stays idle. Holding lane_stop against an idle lane is harmless.
- busy=1 in every state except IDLE.

## Timing
- Reset values: hdr_fifo_rd=0, lane_hdr_we=0, lane_hdr_word=0, lane_start=0, lane_stop=0, lane_nonce_size=0, busy=0, job_done=0, job_aborted=0. State is IDLE.
- job_go to lane_start: 2 cycles minimum (IDLE, then WAIT_READY with acks already high).
- First hdr_fifo_rd occurs in the cycle after lane_start. Lanes leave init on the lane_start edge, so no words are lost.
- LOAD lasts a minimum of 20 cycles with a non-empty FIFO.
- Lane acks drop one cycle after start, so acks are guaranteed low before RUN is entered.
- Completion detect: job_done is asserted 1 cycle after the last ack rises (RUN to DONE).
- Simultaneous events:
  - abort and found in the same cycle are treated as a single kill.
  - A kill arriving in the same cycle as all acks rising in RUN counts as natural completion (job_aborted=0).
- rst mid-job returns to IDLE immediately. Lanes share rst. Partially read FIFO contents are the host's responsibility (host flushes the FIFO).

## Configuration
- SCHED_STATS_EN defined: adds output ports job_cnt[15:0] and run_cycles[31:0].
  - job_cnt increments on every job_done and wraps at 16'hFFFF->0.
  - run_cycles clears at START and counts cycles in LOAD, RUN and STOPPING, saturating at 32'hFFFFFFFF. It holds its value in IDLE.
  - Both counters reset to 0.
- SCHED_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- NUM_LANES=4, nonce_range=32'h100, 20 words preloaded, job_go -> lane_nonce_size=32'h40; lane_start=4'hF for 1 cycle; 20 consecutive lane_hdr_we; job_done with job_aborted=0 after all acks rise.
- FIFO empties after word 7, refilled 10 cycles later -> hdr_fifo_rd/lane_hdr_we deasserted during the gap; exactly 20 words delivered; no lane_stop.
- abort at word 12 of LOAD -> remaining 8 words still read; then lane_stop=1 until acks are all ones; job_done with job_aborted=1.
- found in RUN with lane 2 already idle -> lane_stop held until the remaining 3 acks rise; one job_done pulse.
- job_go while busy, and job_go with lane_stop_ack=4'b1011 -> second job_go ignored; lane_start withheld until ack=4'hF.
- rst asserted in RUN -> next cycle all outputs at reset values; a new job runs normally afterwards; with SCHED_STATS_EN, job_cnt=0 after reset.
